// File: rtl/pool_pkg.sv
// Shared definitions for the max-pool stage: default sizes and state/mode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pool_pkg;

    localparam int DW_DEF     = 8;
    localparam int POOL_N_DEF = 4;

    // Window mode, captured from epol when a window opens.
    typedef enum logic {
        MODE_PASS,
        MODE_MAX
    } pool_mode_t;

    // IDLE: no partial window held (cnt==0). ACCUM: partial window in progress.
    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } pool_state_t;

endpackage

// File: rtl/max_cmp.sv
// Combinational signed two-input maximum; on a tie the first operand (a) wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a = running maximum, b = candidate sample, y = signed max(a, b), DW bits.
module max_cmp
    import pool_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    // Strict greater-than: b replaces a only when it is larger, so ties keep a.
    assign y = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/pool_unit.sv
// Streaming max-pool: reduces POOL_N accepted samples to one signed max (epol=1) or passes samples through (epol=0).
// Latency: 1 cycle from the accept that completes a result (pass sample, last sample, or flush) to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; result register held stable while out_valid && !out_ready.
// Ports: CLK/rst_n clock and async active-low reset; epol pooling enable (sampled at window start);
//        flush closes a partial window; in_valid/in_ready/data_in upstream; out_valid/out_ready/data_out
//        downstream; busy is high while a partial window is held.
module pool_unit
    import pool_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int POOL_N = POOL_N_DEF
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          epol,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_out,
    output logic          busy
);

    localparam int CW = $clog2(POOL_N);
    localparam logic [CW-1:0] CNT_LAST = CW'(POOL_N - 1);

    pool_state_t   state_q, state_d;
    pool_mode_t    mode_q, mode_d;
    pool_mode_t    win_mode;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          oval_q, oval_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] max_y;
    logic          accept;
    logic          flush_req;

    // Single comparator serves both the accumulate path and the final/flush
    // path: both need smax(acc, data_in).
    max_cmp #(.DW(DW)) u_max (
        .a (acc_q),
        .b (data_in),
        .y (max_y)
    );

    assign in_ready  = !oval_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign flush_req = flush || pend_q;
    assign out_valid = oval_q;
    assign data_out  = dout_q;
    assign busy      = (state_q == S_ACCUM);

    // The mode of the window a sample belongs to: epol when it opens a new
    // window, otherwise the mode latched at window start.
    assign win_mode = (state_q == S_IDLE) ? (epol ? MODE_MAX : MODE_PASS) : mode_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        oval_d  = oval_q;
        pend_d  = pend_q;

        if (oval_q && out_ready) begin
            oval_d = 1'b0;
        end

        if (accept) begin
            if (state_q == S_IDLE) begin
                mode_d = win_mode;
            end
            if (win_mode == MODE_PASS) begin
                dout_d = data_in;
                oval_d = 1'b1;
            end else if (state_q == S_IDLE) begin
                if (flush_req) begin
                    // Flush on the opening sample: a window of one.
                    dout_d = data_in;
                    oval_d = 1'b1;
                end else begin
                    acc_d = data_in;
                    cnt_d = CW'(1);
                end
            end else if ((cnt_q == CNT_LAST) || flush_req) begin
                dout_d = max_y;
                oval_d = 1'b1;
                cnt_d  = '0;
            end else begin
                acc_d = max_y;
                cnt_d = cnt_q + CW'(1);
            end
        end else if ((state_q == S_ACCUM) && flush_req) begin
            // Flush without a sample emits acc as-is, but only into a free
            // output slot; otherwise remember it until the slot frees.
            if (in_ready) begin
                dout_d = acc_q;
                oval_d = 1'b1;
                cnt_d  = '0;
            end else begin
                pend_d = 1'b1;
            end
        end

        // A pending flush has no meaning once the window is closed.
        if (cnt_d == '0) begin
            pend_d = 1'b0;
        end

        state_d = (cnt_d != '0) ? S_ACCUM : S_IDLE;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_PASS;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            oval_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pool_unit.sv
// Bench for pool_unit: directed vector table, hand-written reset sequence, and
// randomized traffic against a window/queue-level reference model.
module tb_pool_unit;

    localparam int DW     = 8;
    localparam int POOL_N = 4;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          epol;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pool_unit #(.DW(DW), .POOL_N(POOL_N)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .epol      (epol),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ep;
        logic       fl;
        logic       ordy;
        logic       e_irdy;  // in_ready before the edge
        logic       e_ov;    // out_valid after the edge
        logic [7:0] e_do;    // data_out after the edge (checked when e_ov)
        logic       e_busy;  // busy after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [7:0] din, input logic ep,
                       input logic fl, input logic ordy, input logic e_irdy,
                       input logic e_ov, input logic [7:0] e_do, input logic e_busy);
        vec_t v;
        v.iv = iv; v.din = din; v.ep = ep; v.fl = fl; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_do = e_do; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ep,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        data_in   = d;
        epol      = ep;
        flush     = fl;
        out_ready = ordy;
    endtask

    function automatic logic [7:0] qmax(input logic [7:0] q[$]);
        logic [7:0] m;
        m = q[0];
        foreach (q[i]) begin
            if ($signed(q[i]) > $signed(m)) m = q[i];
        end
        return m;
    endfunction

    // Reference model state for the random phase.
    logic [7:0] win[$];
    logic       m_full;
    logic [7:0] m_val;
    logic       m_pend;

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;

        //------------------------------------------------------------ reset
        repeat (2) @(negedge CLK);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        //------------------------------------------------------------ vector table
        //   iv  din    ep  fl  ordy irdy ov  do     busy
        // pass-through
        add(1, 8'h05, 0, 0, 1, 1, 1, 8'h05, 0);
        add(1, 8'h7F, 0, 0, 1, 1, 1, 8'h7F, 0);
        add(1, 8'h00, 0, 0, 1, 1, 1, 8'h00, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0);
        // max-pool
        add(1, 8'h03, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h10, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h0A, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h0F, 1, 0, 1, 1, 1, 8'h10, 0);
        // signed values and ties
        add(1, 8'h80, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'hF0, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'hF0, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h81, 1, 0, 1, 1, 1, 8'hF0, 0);
        // flush of a partial window, then a full window
        add(1, 8'h04, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h09, 1, 0, 1, 1, 0, 8'h00, 1);
        add(0, 8'h00, 1, 1, 1, 1, 1, 8'h09, 0);
        add(1, 8'h01, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h01, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h01, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h01, 1, 0, 1, 1, 1, 8'h01, 0);
        // epol dropped mid-window: ignored until the next window
        add(1, 8'h02, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h01, 0, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h03, 0, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h00, 0, 0, 1, 1, 1, 8'h03, 0);
        add(1, 8'h07, 0, 0, 1, 1, 1, 8'h07, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0);
        // backpressure, then simultaneous pop and accept
        add(1, 8'h20, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h11, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h12, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h13, 1, 0, 1, 1, 1, 8'h20, 0);
        add(1, 8'h05, 1, 0, 0, 0, 1, 8'h20, 0);
        add(1, 8'h05, 1, 0, 0, 0, 1, 8'h20, 0);
        add(1, 8'h05, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h06, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h07, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h01, 1, 0, 1, 1, 1, 8'h07, 0);
        // flush on the opening sample, idle flush, flush with a sample
        add(1, 8'h30, 1, 1, 1, 1, 1, 8'h30, 0);
        add(0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0);
        add(1, 8'h40, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 8'h45, 1, 1, 1, 1, 1, 8'h45, 0);
        add(0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].din, vecs[i].ep, vecs[i].fl, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_irdy);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_ov) chk($sformatf("vec%0d_data_out", i), data_out, vecs[i].e_do);
            @(negedge CLK);
        end

        //------------------------------------------------------------ reset mid-window
        drive(1, 8'h11, 1, 0, 1);
        @(negedge CLK);
        drive(1, 8'h22, 1, 0, 1);
        @(posedge CLK);
        #1;
        chk("rst_pre_busy", busy, 1);
        @(negedge CLK);
        drive(0, 8'h00, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("rst_idle%0d_out_valid", k), out_valid, 0);
            chk($sformatf("rst_idle%0d_busy", k), busy, 0);
            @(negedge CLK);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1, 8'(k), 1, 0, 1);
            @(posedge CLK);
            #1;
            chk($sformatf("rst_win%0d_out_valid", k), out_valid, (k == 4) ? 1 : 0);
            chk($sformatf("rst_win%0d_busy", k), busy, (k == 4) ? 0 : 1);
            @(negedge CLK);
        end
        chk("rst_win_data_out", data_out, 8'h04);

        //------------------------------------------------------------ randomized vs model
        drive(0, 8'h00, 0, 0, 1);
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        win.delete();
        m_full = 1'b0;
        m_val  = 8'h00;
        m_pend = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            logic       iv, ep, fl, ordy, m_irdy, acc, emit;
            logic [7:0] d, ev;
            iv   = ($urandom_range(0, 3) != 0);
            d    = 8'($urandom);
            ep   = ($urandom_range(0, 4) != 0);
            fl   = ($urandom_range(0, 11) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            drive(iv, d, ep, fl, ordy);

            m_irdy = !m_full || ordy;
            acc    = iv && m_irdy;
            emit   = 1'b0;
            ev     = 8'h00;
            if (acc) begin
                if (win.size() == 0 && !ep) begin
                    emit = 1'b1;
                    ev   = d;
                end else begin
                    win.push_back(d);
                    if (win.size() == POOL_N || fl || m_pend) begin
                        emit = 1'b1;
                        ev   = qmax(win);
                        win.delete();
                    end
                end
            end else if (win.size() != 0 && (fl || m_pend)) begin
                if (m_irdy) begin
                    emit = 1'b1;
                    ev   = qmax(win);
                    win.delete();
                end else begin
                    m_pend = 1'b1;
                end
            end
            if (win.size() == 0) m_pend = 1'b0;

            #1;
            chk("rand_in_ready", in_ready, m_irdy);
            @(posedge CLK);
            if (emit) begin
                m_full = 1'b1;
                m_val  = ev;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
            #1;
            chk("rand_out_valid", out_valid, m_full);
            chk("rand_busy", busy, (win.size() != 0) ? 1 : 0);
            if (m_full) chk("rand_data_out", data_out, m_val);
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
